nr_divider: RTL and testbench
=============================

# nr_divider

Sequential 32-bit signed divider using the non-restoring algorithm. It retires one quotient bit per clock and reports how many add and subtract operations it used. It is the inverse companion of the team's Booth multiplier and has the same start/done handshake and operation-count outputs, so the two can share a test harness and a controller. The result is C-style truncating division: the quotient rounds toward zero and the remainder takes the sign of the dividend.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous, active-low reset.
- inp  input  1  start strobe, sampled at posedge clk.
- dvnd  input  32  signed dividend, sampled only when inp=1.
- dvsr  input  32  signed divisor, sampled only when inp=1.
- done  output  1  high when idle and the result is valid.
- quo  output  32  signed quotient.
- rem  output  32  signed remainder.
- adds  output  6  count of add operations performed.
- subs  output  6  count of subtract operations performed.
- dbz  output  1  divide-by-zero flag for the last operation.

## Operation
- **States.** IDLE, CHECK, ITER (32 cycles), FIX.
- **Reset.** rstn=0 forces IDLE immediately with done=1, quo=0, rem=0, adds=0, subs=0, dbz=0. This holds even mid-operation; nothing partial survives.
- **Load (inp=1, any state).**
  - Latch the operands.
  - Clear quo, rem, adds, subs, dbz; set done=0; go to CHECK.
  - inp during CHECK, ITER or FIX aborts the current operation and restarts with the new operands.
- **CHECK, divisor zero.**
  - If dvsr==0: quo=32'hFFFFFFFF, rem=dvnd, dbz=1, done=1, counters stay 0; go to IDLE.
- **CHECK, divisor non-zero.**
  - Form |dvnd| and |dvsr| as 33-bit unsigned values (|-2^31| = 2^31).
  - Record sign_q = sign(dvnd) XOR sign(dvsr) and sign_r = sign(dvnd).
  - Clear the 33-bit signed partial remainder P; go to ITER.
- **ITER, one step per cycle, dividend magnitude bits consumed MSB first.**
  - Shift P left 1 and bring in the next dividend bit.
  - If the previous P was ≥0 (always true for step 1): subtract |dvsr| and increment subs.
  - Otherwise: add |dvsr| and increment adds.
  - The quotient bit is 1 if the new P ≥0, else 0.
  - After 32 steps go to FIX.
- **FIX.**
  - If P<0: add |dvsr| to P and increment adds (restoration).
  - Apply the sign: quo = sign_q ? -Q : Q; rem = sign_r ? -P : P, both truncated to 32 bits.
  - Set done=1; go to IDLE.
- **Overflow.** -2^31 / -1 gives quo=32'h80000000 and rem=0 (wraps, no flag).
- **Invariant.** For any non-zero divisor, adds+subs = 32 + (restoration performed ? 1 : 0), so the maximum is 33, which fits in 6 bits.
- **Hold.** In IDLE, all outputs hold their values until the next inp or reset.

## Timing
- Edge 0 (inp=1): done falls after this edge.
- Edge 1: CHECK. For a zero divisor, done=1 and the result are visible after this edge (latency 1).
- Edges 2–33: the 32 ITER steps.
- Edge 34: FIX. done=1 and the result are visible after this edge (latency 34).
- quo, rem, adds and subs may change while done=0. Consumers sample them only when done=1.
- inp held high re-loads on every edge; the operation proceeds once inp drops.
- The quo and rem ports are registered outputs. adds and subs are live counters.

## Test plan
- **Basic divide.** 100/7 -> quo=14, rem=2, dbz=0, done=1 at edge 34, adds+subs ∈ {32,33}.
- **Sign handling.** -100/7 -> quo=-14, rem=-2; 100/-7 -> quo=-14, rem=2; -100/-7 -> quo=14, rem=-2.
- **Zero dividend.** 0/5 -> quo=0, rem=0, subs=1, adds=32.
- **Edge operands.**
  - 12345/0 -> done=1 after edge 1, dbz=1, quo=32'hFFFFFFFF, rem=12345, adds=subs=0.
  - -2^31/-1 -> quo=32'h80000000, rem=0.
  - -2^31/1 -> quo=32'h80000000, rem=0.
- **Restart and reset mid-operation.**
  - Start 100/7, pulse inp at edge 10 with 50/3 -> quo=16, rem=2, done at edge 44.
  - Assert rstn=0 mid-ITER -> immediately done=1 and all other outputs 0.
- **Randomized check.** 1000 random operand pairs against a reference model for truncating division. Check the invariant |rem|<|dvsr| with rem having dvnd's sign (or zero).

Source files
------------

// File: rtl/nr_divider_if.sv
// Start/done handshake and result bus of the non-restoring divider.
// Same shape as the Booth multiplier bus so both can share a controller.
interface nr_divider_if;
    logic        inp;
    logic [31:0] dvnd;
    logic [31:0] dvsr;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [5:0]  adds;
    logic [5:0]  subs;
    logic        dbz;

    modport master (
        output inp, dvnd, dvsr,
        input  done, quo, rem, adds, subs, dbz
    );

    modport slave (
        input  inp, dvnd, dvsr,
        output done, quo, rem, adds, subs, dbz
    );
endinterface

// File: rtl/nr_divider.sv
// 32-bit signed non-restoring divider, one quotient bit per clock, C-style
// truncating result with add/subtract operation counts.
module nr_divider (
    input  logic         clk,
    input  logic         rstn,
    nr_divider_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        FIX   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] dvnd_r;
    logic [31:0] dvsr_r;
    logic [32:0] d_abs_r;
    logic [31:0] q_r;
    logic [32:0] p_r;
    logic [4:0]  cnt_r;
    logic        sign_q_r;
    logic        sign_r_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [5:0]  adds_r;
    logic [5:0]  subs_r;
    logic        done_r;
    logic        dbz_r;
    logic [32:0] p_shift_s;
    logic [32:0] p_new_s;
    logic [31:0] rem_mag_s;
    logic [31:0] dvnd_mag_s;

    // Magnitude of a signed 32-bit value widened so that |-2^31| is representable.
    function automatic logic [32:0] mag33(input logic [31:0] v);
        logic [32:0] m;
        if (v[31]) begin
            m = 33'd0 - {1'b1, v};
        end else begin
            m = {1'b0, v};
        end
        return m;
    endfunction

    assign bus.done = done_r;
    assign bus.quo  = quo_r;
    assign bus.rem  = rem_r;
    assign bus.adds = adds_r;
    assign bus.subs = subs_r;
    assign bus.dbz  = dbz_r;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a start strobe restarts from any state.
    always_comb begin
        state_next_s = state_r;
        if (bus.inp) begin
            state_next_s = CHECK;
        end else begin
            case (state_r)
                IDLE:    state_next_s = IDLE;
                CHECK:   state_next_s = (dvsr_r == 32'd0) ? IDLE : ITER;
                ITER:    state_next_s = (cnt_r == 5'd31) ? FIX : ITER;
                FIX:     state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // One non-restoring step, final restoration and operand magnitude.
    always_comb begin
        p_shift_s = {p_r[31:0], q_r[31]};
        if (!p_r[32]) begin
            p_new_s = p_shift_s - d_abs_r;
        end else begin
            p_new_s = p_shift_s + d_abs_r;
        end
        // The restored remainder is below 2^31, so 32 bits carry it exactly.
        if (p_r[32]) begin
            rem_mag_s = p_r[31:0] + d_abs_r[31:0];
        end else begin
            rem_mag_s = p_r[31:0];
        end
        if (dvnd_r[31]) begin
            dvnd_mag_s = 32'd0 - dvnd_r;
        end else begin
            dvnd_mag_s = dvnd_r;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dvnd_r   <= 32'd0;
            dvsr_r   <= 32'd0;
            d_abs_r  <= 33'd0;
            q_r      <= 32'd0;
            p_r      <= 33'd0;
            cnt_r    <= 5'd0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            quo_r    <= 32'd0;
            rem_r    <= 32'd0;
            adds_r   <= 6'd0;
            subs_r   <= 6'd0;
            done_r   <= 1'b1;
            dbz_r    <= 1'b0;
        end else if (bus.inp) begin
            dvnd_r <= bus.dvnd;
            dvsr_r <= bus.dvsr;
            quo_r  <= 32'd0;
            rem_r  <= 32'd0;
            adds_r <= 6'd0;
            subs_r <= 6'd0;
            dbz_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state_r)
                CHECK: begin
                    if (dvsr_r == 32'd0) begin
                        quo_r  <= 32'hFFFF_FFFF;
                        rem_r  <= dvnd_r;
                        dbz_r  <= 1'b1;
                        done_r <= 1'b1;
                    end else begin
                        d_abs_r  <= mag33(dvsr_r);
                        q_r      <= dvnd_mag_s;
                        p_r      <= 33'd0;
                        cnt_r    <= 5'd0;
                        sign_q_r <= dvnd_r[31] ^ dvsr_r[31];
                        sign_r_r <= dvnd_r[31];
                    end
                end
                ITER: begin
                    // q_r shifts out dividend bits while shifting in quotient bits.
                    p_r   <= p_new_s;
                    q_r   <= {q_r[30:0], ~p_new_s[32]};
                    cnt_r <= cnt_r + 5'd1;
                    if (!p_r[32]) begin
                        subs_r <= subs_r + 6'd1;
                    end else begin
                        adds_r <= adds_r + 6'd1;
                    end
                end
                FIX: begin
                    if (p_r[32]) begin
                        adds_r <= adds_r + 6'd1;
                    end else begin
                        adds_r <= adds_r;
                    end
                    quo_r  <= sign_q_r ? (32'd0 - q_r) : q_r;
                    rem_r  <= sign_r_r ? (32'd0 - rem_mag_s) : rem_mag_s;
                    done_r <= 1'b1;
                end
                default: begin
                    done_r <= done_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nr_divider.sv
// Scoreboard bench for nr_divider: stimulus pushes reference results, a
// monitor pops and compares them on every rising done.
module tb_nr_divider;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        logic [5:0]  adds;
        logic [5:0]  subs;
        int          lat;
        int          issue;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    nr_divider_if bus();

    nr_divider dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: truncating division with wide integers; the operation counts
    // follow from the quotient bits (step i+1 subtracts iff quotient bit i is 1,
    // restoration happens iff the last quotient bit is 0).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int issue);
        exp_t   e;
        longint la;
        longint lb;
        longint lq;
        longint lr;
        longint mq;
        logic [31:0] qm;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        e.a = a;
        e.b = b;
        e.issue = issue;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
            e.adds = 6'd0;
            e.subs = 6'd0;
            e.lat = 1;
        end else begin
            lq = la / lb;
            lr = la % lb;
            e.q = lq[31:0];
            e.r = lr[31:0];
            e.z = 1'b0;
            mq = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
            qm = mq[31:0];
            e.subs = 6'(1 + $countones(qm[31:1]));
            e.adds = 6'(32 + (qm[0] ? 0 : 1)) - e.subs;
            e.lat = 34;
        end
        return e;
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(a, b, cyc + 1));
        bus.inp  = 1'b1;
        bus.dvnd = a;
        bus.dvsr = b;
        @(negedge clk);
        bus.inp = 1'b0;
        check("done_fall", {63'd0, bus.done}, 64'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("timeout_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: compare against the oldest expectation whenever done rises.
    initial begin
        logic prev_done;
        exp_t e;
        logic [31:0] ma;
        logic [31:0] mr;
        logic [31:0] mb;
        logic inv_ok;
        prev_done = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_done = bus.done;
            end else begin
                if (bus.done && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("quo", {32'd0, bus.quo}, {32'd0, e.q});
                        check("rem", {32'd0, bus.rem}, {32'd0, e.r});
                        check("dbz", {63'd0, bus.dbz}, {63'd0, e.z});
                        check("adds", {58'd0, bus.adds}, {58'd0, e.adds});
                        check("subs", {58'd0, bus.subs}, {58'd0, e.subs});
                        check("latency", 64'(cyc - e.issue), 64'(e.lat));
                        if (!e.z) begin
                            ma = e.a[31] ? 32'd0 - e.a : e.a;
                            mb = e.b[31] ? 32'd0 - e.b : e.b;
                            mr = bus.rem[31] ? 32'd0 - bus.rem : bus.rem;
                            inv_ok = (mr < mb) && ((bus.rem == 32'd0) || (bus.rem[31] == e.a[31]));
                            check("rem_invariant", {63'd0, inv_ok}, 64'd1);
                            check("op_count", 64'(bus.adds + bus.subs) - 64'd32, 64'(e.adds + e.subs) - 64'd32);
                        end
                    end
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        bus.inp  = 1'b0;
        bus.dvnd = 32'd0;
        bus.dvsr = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_done", {63'd0, bus.done}, 64'd1);
        check("rst_quo", {32'd0, bus.quo}, 64'd0);
        check("rst_rem", {32'd0, bus.rem}, 64'd0);
        check("rst_adds", {58'd0, bus.adds}, 64'd0);
        check("rst_subs", {58'd0, bus.subs}, 64'd0);
        check("rst_dbz", {63'd0, bus.dbz}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        #1;

        start(32'd100, 32'd7);                       wait_done();
        start(-32'sd100, 32'd7);                     wait_done();
        start(32'd100, -32'sd7);                     wait_done();
        start(-32'sd100, -32'sd7);                   wait_done();
        start(32'd0, 32'd5);                         wait_done();
        start(32'd12345, 32'd0);                     wait_done();
        start(32'h8000_0000, 32'hFFFF_FFFF);         wait_done();
        start(32'h8000_0000, 32'd1);                 wait_done();

        // Restart with new operands ten edges into an operation.
        start(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #1;
        void'(exp_q.pop_back());
        start(32'd50, 32'd3);
        wait_done();

        // Reset in the middle of the iteration phase.
        start(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_done", {63'd0, bus.done}, 64'd1);
        check("midrst_quo", {32'd0, bus.quo}, 64'd0);
        check("midrst_rem", {32'd0, bus.rem}, 64'd0);
        check("midrst_adds", {58'd0, bus.adds}, 64'd0);
        check("midrst_subs", {58'd0, bus.subs}, 64'd0);
        check("midrst_dbz", {63'd0, bus.dbz}, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;

        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            if ($urandom_range(0, 49) == 0) b = 32'd0;
            if ($urandom_range(0, 49) == 0) a = 32'h8000_0000;
            start(a, b);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
